// File: rtl/serial_sub_if.sv
// serial_sub_if: start/operand/result bundle for the digit-serial subtractor.
interface serial_sub_if #(
   parameter int DATAWIDTH = 32
);
   logic                 start, busy, done, borrow, ovf;
   logic [DATAWIDTH-1:0] a, b, diff;
   modport master (output start, a, b, input busy, done, diff, borrow, ovf);
   modport slave (input start, a, b, output busy, done, diff, borrow, ovf);
endinterface

// File: rtl/serial_sub.sv
// serial_sub: digit-serial subtractor, diff = a - b one DIGITWIDTH slice per clock, LSB digit first.
// Define SERIAL_SUB_OVF_EN to drive the signed-overflow flag on ovf (tied low otherwise).
module serial_sub #(
   parameter int DATAWIDTH  = 32,
   parameter int DIGITWIDTH = 8
) (
   input logic         Clk,
   input logic         Rst,
   serial_sub_if.slave bus
);
   localparam int N  = DATAWIDTH / DIGITWIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   if (DATAWIDTH % DIGITWIDTH != 0) begin : g_bad_width
      $error("serial_sub: DATAWIDTH must be a multiple of DIGITWIDTH");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   state_e                          state_q, state_d;
   logic [N-1:0][DIGITWIDTH-1:0]    a_q, b_q, diff_q;
   logic [CW-1:0]                   cnt_q;
   logic                            bi_q, borrow_q, bo, accept, last;
   logic [DIGITWIDTH-1:0]           d;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      accept  = bus.start && (state_q != RUN);
      last    = (cnt_q == CW'(N - 1));
      state_d = state_q == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
   end
   always_comb begin
      bus.busy   = (state_q == RUN);
      bus.done   = (state_q == DONE);
      bus.diff   = diff_q;
      bus.borrow = borrow_q;
   end
   // One digit per cycle; the borrow ripples through bi_q between cycles.
   always_comb
      {bo, d} = {1'b0, a_q[cnt_q]} - {1'b0, b_q[cnt_q]} - {{DIGITWIDTH{1'b0}}, bi_q};
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bi_q     <= 1'b0;
         borrow_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         cnt_q <= '0;
         bi_q  <= 1'b0;
      end else if (state_q == RUN) begin
         diff_q[cnt_q] <= d;
         bi_q          <= bo;
         cnt_q         <= cnt_q + 1'b1;
         if (last) borrow_q <= bo;
      end
`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) ovf_q <= 1'b0;
      else if (accept) ovf_q <= 1'b0;
      else if (state_q == RUN && last)
         ovf_q <= (a_q[N-1][DIGITWIDTH-1] != b_q[N-1][DIGITWIDTH-1]) &&
                  (d[DIGITWIDTH-1] != a_q[N-1][DIGITWIDTH-1]);
   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub (32/8 main instance, 8/8 and 16/4 corner instances).
module tb_serial_sub;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;
   serial_sub_if #(.DATAWIDTH(32)) bus ();
   serial_sub_if #(.DATAWIDTH(8))  bus8 ();
   serial_sub_if #(.DATAWIDTH(16)) bus16 ();
   serial_sub #(.DATAWIDTH(32), .DIGITWIDTH(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
   serial_sub #(.DATAWIDTH(8), .DIGITWIDTH(8)) dut8 (.Clk(Clk), .Rst(Rst), .bus(bus8));
   serial_sub #(.DATAWIDTH(16), .DIGITWIDTH(4)) dut16 (.Clk(Clk), .Rst(Rst), .bus(bus16));
   typedef struct packed {
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } exp_t;
   exp_t sb[$];
   int vectors = 0;
   int errors  = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.d  = a - b;
      e.bo = (a < b);
`ifdef SERIAL_SUB_OVF_EN
      e.ov = (a[31] != b[31]) && (e.d[31] != a[31]);
`else
      e.ov = 1'b0;
`endif
      sb.push_back(e);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      @(negedge Clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
   endtask
   task automatic wait_done(input string tag, input int lat);
      int   cyc    = 0;
      int   busy_n = 0;
      exp_t e;
      while (!bus.done && cyc < 20) begin
         busy_n += int'(bus.busy);
         @(negedge Clk);
         cyc++;
      end
      check({tag, "_done"}, bus.done, 1);
      if (!bus.done) begin
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_busy_cycles"}, busy_n, lat);
      check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check({tag, "_diff"}, bus.diff, e.d);
      check({tag, "_borrow"}, bus.borrow, e.bo);
      check({tag, "_ovf"}, bus.ovf, e.ov);
   endtask
   task automatic count_dones(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge Clk);
         n += int'(bus.done);
      end
   endtask
   initial begin
      int n;
      int cyc;
      logic [15:0] e16;
      {bus.start, bus.a, bus.b}       = '0;
      {bus8.start, bus8.a, bus8.b}    = '0;
      {bus16.start, bus16.a, bus16.b} = '0;
      repeat (2) @(negedge Clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_borrow", bus.borrow, 0);
      check("rst_ovf", bus.ovf, 0);
      Rst = 1'b0;
      @(negedge Clk);
      issue(32'h0000_0010, 32'h0000_0001);
      wait_done("basic", 4);
      @(negedge Clk);
      check("basic_single_done", bus.done, 0);
      issue(32'h0000_0001, 32'h0000_0002);
      wait_done("full_borrow", 4);
      @(negedge Clk);
      issue(32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait_done("equal", 4);
      @(negedge Clk);
      issue(32'h8000_0000, 32'h0000_0001);
      wait_done("ovf_neg", 4);
      @(negedge Clk);
      issue(32'h7FFF_FFFF, 32'hFFFF_FFFF);
      wait_done("ovf_pos", 4);
      @(negedge Clk);
      issue(32'd5, 32'd3);
      bus.start = 1'b1;
      bus.a     = 32'd9;
      bus.b     = 32'd1;
      @(negedge Clk);
      bus.start = 1'b0;
      wait_done("ignored_start", 3);
      issue(32'd9, 32'd1);
      wait_done("back_to_back", 4);
      count_dones(6, n);
      check("no_extra_done", n, 0);
      for (int i = 0; i < 6; i++) begin
         issue($urandom, $urandom);
         wait_done("random", 4);
      end
      @(negedge Clk);
      issue(32'h1234_5678, 32'h0000_0001);
      @(negedge Clk);
      #2 Rst = 1'b1;
      #1;
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_done", bus.done, 0);
      check("async_rst_diff", bus.diff, 0);
      check("async_rst_borrow", bus.borrow, 0);
      check("async_rst_ovf", bus.ovf, 0);
      sb.delete();
      @(negedge Clk);
      Rst = 1'b0;
      count_dones(8, n);
      check("aborted_no_done", n, 0);
      issue(32'd100, 32'd1);
      wait_done("after_rst", 4);
      @(negedge Clk);
      bus8.start = 1'b1;
      bus8.a     = 8'h00;
      bus8.b     = 8'h01;
      @(negedge Clk);
      bus8.start = 1'b0;
      cyc = 0;
      while (!bus8.done && cyc < 20) begin
         @(negedge Clk);
         cyc++;
      end
      check("w8_done", bus8.done, 1);
      check("w8_latency", cyc, 1);
      check("w8_diff", bus8.diff, 8'hFF);
      check("w8_borrow", bus8.borrow, 1);
      e16 = 16'h1234 - 16'h4321;
      bus16.start = 1'b1;
      bus16.a     = 16'h1234;
      bus16.b     = 16'h4321;
      @(negedge Clk);
      bus16.start = 1'b0;
      cyc = 0;
      while (!bus16.done && cyc < 20) begin
         @(negedge Clk);
         cyc++;
      end
      check("w16_done", bus16.done, 1);
      check("w16_latency", cyc, 4);
      check("w16_diff", bus16.diff, e16);
      check("w16_borrow", bus16.borrow, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
